// File: rtl/router_modport.sv
// 1x3 byte-serial packet router with parity check and three 16-deep output FIFOs.
// Optional per-port read timeout flush enabled by defining ROUTER_SOFT_RESET_EN.
module router_modport #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       error,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic [2:0] o_fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PARITY = 3'd2,
    S_FULL   = 3'd3,
    S_DROP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          r_ret;
  logic [1:0]      r_addr;
  logic [5:0]      r_len;
  logic [7:0]      r_parity;
  logic            r_error;

  logic [CW-1:0]   r_cnt [3];
  logic [AW-1:0]   r_wp  [3];
  logic [AW-1:0]   r_rp  [3];
  logic [7:0]      r_mem [3][FIFO_DEPTH];
  logic [7:0]      r_dout[3];

  logic [2:0]      w_rd;
  logic [2:0]      w_wr;
  logic [2:0]      w_pop;
  logic [2:0]      w_full;
  logic [2:0]      w_full_nxt;
  logic [2:0]      w_flush;
  logic [CW-1:0]   w_cnt_nxt [3];
  logic [1:0]      w_hdr_addr;
  logic [1:0]      w_tgt;
  logic            w_busy;
  logic            w_xfer;
  logic            w_wr_any;
  logic            w_tgt_flush;
  state_t          w_nxt;

  assign w_rd = {read_enb_2, read_enb_1, read_enb_0};

  always_comb begin
    w_hdr_addr = data_in[1:0];
    for (int n = 0; n < 3; n++) begin
      w_full[n] = (r_cnt[n] == CW'(FIFO_DEPTH));
    end
    // Address 3 is dropped, so it never stalls the source.
    w_busy   = (r_state == S_FULL) ||
               ((r_state == S_IDLE) && (w_hdr_addr != 2'd3) && w_full[w_hdr_addr]);
    w_xfer   = pkt_valid && !w_busy;
    w_tgt    = (r_state == S_IDLE) ? w_hdr_addr : r_addr;
    w_wr_any = w_xfer && (((r_state == S_IDLE) && (w_hdr_addr != 2'd3)) ||
                          (r_state == S_LOAD) || (r_state == S_PARITY));
    for (int n = 0; n < 3; n++) begin
      w_wr[n]       = w_wr_any && (w_tgt == 2'(n));
      w_pop[n]      = w_rd[n] && (r_cnt[n] != '0);
      w_cnt_nxt[n]  = r_cnt[n] + CW'(w_wr[n]) - CW'(w_pop[n]);
      w_full_nxt[n] = (w_cnt_nxt[n] == CW'(FIFO_DEPTH));
    end
    w_tgt_flush = w_flush[r_addr] &&
                  ((r_state == S_LOAD) || (r_state == S_PARITY) || (r_state == S_FULL));
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_xfer) begin
                  if (w_hdr_addr == 2'd3)         w_nxt = S_DROP;
                  else if (data_in[7:2] == 6'd0)  w_nxt = S_PARITY;
                  else                            w_nxt = S_LOAD;
                end
      S_LOAD:   if (w_xfer && (r_len == 6'd1)) w_nxt = S_PARITY;
      S_PARITY: if (w_xfer) w_nxt = S_IDLE;
      S_FULL:   if (!w_full[r_addr]) w_nxt = r_ret;
      S_DROP:   if (w_xfer && (r_len == 6'd0)) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_ret    <= S_IDLE;
      r_addr   <= 2'd0;
      r_len    <= 6'd0;
      r_parity <= 8'h00;
      r_error  <= 1'b0;
    end else begin
      if (w_tgt_flush) begin
        r_state <= S_IDLE;
      end else if (((w_nxt == S_LOAD) || (w_nxt == S_PARITY)) && (r_state != S_FULL) &&
                   w_full_nxt[w_tgt]) begin
        // Park before the next byte can arrive so no write ever hits a full FIFO.
        r_state <= S_FULL;
        r_ret   <= w_nxt;
      end else begin
        r_state <= w_nxt;
      end
      if (w_xfer) begin
        unique case (r_state)
          S_IDLE: begin
            r_addr   <= w_hdr_addr;
            r_len    <= data_in[7:2];
            r_parity <= data_in;
          end
          S_LOAD: begin
            r_len    <= r_len - 6'd1;
            r_parity <= r_parity ^ data_in;
          end
          S_PARITY: r_error <= (data_in != r_parity);
          S_DROP:   r_len   <= r_len - 6'd1;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 3; n++) begin
        r_cnt[n]  <= '0;
        r_wp[n]   <= '0;
        r_rp[n]   <= '0;
        r_dout[n] <= 8'h00;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (w_flush[n]) begin
          r_cnt[n] <= '0;
          r_wp[n]  <= '0;
          r_rp[n]  <= '0;
        end else begin
          if (w_wr[n]) r_wp[n] <= r_wp[n] + AW'(1);
          if (w_pop[n]) begin
            r_rp[n]   <= r_rp[n] + AW'(1);
            r_dout[n] <= r_mem[n][r_rp[n]];
          end
          r_cnt[n] <= w_cnt_nxt[n];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (w_wr[n]) r_mem[n][r_wp[n]] <= data_in;
    end
  end

`ifdef ROUTER_SOFT_RESET_EN
  logic [4:0] r_timer [3];

  // Counts cycles a port holds data that nobody reads; flushes at 30.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 3; n++) r_timer[n] <= 5'd0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (r_timer[n] == 5'd30)                    r_timer[n] <= 5'd0;
        else if ((r_cnt[n] != '0) && !w_rd[n])      r_timer[n] <= r_timer[n] + 5'd1;
        else                                        r_timer[n] <= 5'd0;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 3; n++) w_flush[n] = (r_timer[n] == 5'd30);
  end
`else
  assign w_flush = 3'b000;
`endif

  assign busy        = w_busy;
  assign error       = r_error;
  assign valid_out_0 = (r_cnt[0] != '0);
  assign valid_out_1 = (r_cnt[1] != '0);
  assign valid_out_2 = (r_cnt[2] != '0);
  assign data_out_0  = r_dout[0];
  assign data_out_1  = r_dout[1];
  assign data_out_2  = r_dout[2];
  assign o_fsm_state = r_state;

endmodule

// File: tb/tb_router_modport.sv
// Bench for router_modport: packet table, backpressure/wrap, drop, timeout and reset sequences.
module tb_router_modport;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] rd_en = 3'b000;
  logic       busy, error;
  logic [2:0] vo;
  logic [7:0] d0, d1, d2;
  logic [2:0] st;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  typedef struct {
    int              n;
    logic [4:0][7:0] b;
    logic            exp_err;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  router_modport dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .busy(busy), .error(error),
    .read_enb_0(rd_en[0]), .read_enb_1(rd_en[1]), .read_enb_2(rd_en[2]),
    .valid_out_0(vo[0]), .valid_out_1(vo[1]), .valid_out_2(vo[2]),
    .data_out_0(d0), .data_out_1(d1), .data_out_2(d2),
    .o_fsm_state(st)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                              logic [7:0] b3, logic [7:0] b4, logic e);
    vec_t v;
    v.n = n;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.exp_err = e;
    return v;
  endfunction

  function automatic void push(input logic [1:0] p, input logic [7:0] b);
    case (p)
      2'd0: exp_q0.push_back(b);
      2'd1: exp_q1.push_back(b);
      2'd2: exp_q2.push_back(b);
      default: ;
    endcase
  endfunction

  function automatic int qsize(input int p);
    case (p)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(input int p);
    case (p)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic logic [7:0] dout(input int p);
    case (p)
      0: return d0;
      1: return d1;
      default: return d2;
    endcase
  endfunction

  // Entered and left at a falling edge; the byte moves on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, output logic ok);
    int guard = 0;
    pkt_valid = 1'b1;
    data_in   = b;
    #1;
    while (busy && guard < 300) begin
      @(negedge clk);
      #1;
      guard++;
    end
    ok = !busy;
    if (!ok) chk("send_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic read_one(input int p);
    logic [7:0] e;
    rd_en[p] = 1'b1;
    @(negedge clk);
    rd_en[p] = 1'b0;
    e = qpop(p);
    chk($sformatf("data_out_%0d", p), 32'(dout(p)), 32'(e));
  endtask

  task automatic drain_all();
    for (int p = 0; p < 3; p++)
      chk($sformatf("valid_before_%0d", p), 32'(vo[p]), 32'(qsize(p) != 0));
    for (int p = 0; p < 3; p++) begin
      while (qsize(p) > 0) read_one(p);
      chk($sformatf("valid_after_%0d", p), 32'(vo[p]), 32'd0);
    end
  endtask

  task automatic send_vec(input vec_t v);
    logic ok;
    for (int j = 0; j < v.n; j++) begin
      send_byte(v.b[j], ok);
      if (ok && v.b[0][1:0] != 2'd3) push(v.b[0][1:0], v.b[j]);
    end
    pkt_valid = 1'b0;
  endtask

  initial begin
    logic       ok;
    logic [7:0] fb[20];
    logic [7:0] par;

    vecs[0] = mk(5, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 1'b0);
    vecs[1] = mk(5, 8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF, 1'b1);
    vecs[2] = mk(3, 8'h07, 8'h99, 8'h77, 8'h00, 8'h00, 1'b1);
    vecs[3] = mk(3, 8'h04, 8'hA5, 8'hA1, 8'h00, 8'h00, 1'b0);
    vecs[4] = mk(4, 8'h0A, 8'h5A, 8'hC3, 8'h93, 8'h00, 1'b0);
    vecs[5] = mk(4, 8'h09, 8'h01, 8'h02, 8'h0B, 8'h00, 1'b1);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(vo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_dout", {8'h00, d0, d1, d2}, 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Packet table, each followed by an error check and a full drain
    for (int i = 0; i < 6; i++) begin
      send_vec(vecs[i]);
      chk($sformatf("error_vec%0d", i), 32'(error), 32'(vecs[i].exp_err));
      drain_all();
    end

    // Backpressure on port 0: 20-byte packet, 16-deep FIFO, pointers wrap
    fb[0] = 8'h48;
    par = fb[0];
    for (int k = 1; k < 19; k++) begin
      fb[k] = 8'(k * 13 + 1);
      par ^= fb[k];
    end
    fb[19] = par;
    for (int k = 0; k < 16; k++) begin
      send_byte(fb[k], ok);
      if (ok) push(2'd0, fb[k]);
    end
    pkt_valid = 1'b1;
    data_in = fb[16];
    #1;
    chk("busy_when_full", 32'(busy), 32'd1);
    chk("valid0_full", 32'(vo[0]), 32'd1);
    read_one(0);
    send_byte(fb[16], ok);
    if (ok) push(2'd0, fb[16]);
    data_in = fb[17];
    #1;
    chk("busy_refull", 32'(busy), 32'd1);
    pkt_valid = 1'b0;
    @(negedge clk);
    while (qsize(0) > 0) read_one(0);
    for (int k = 17; k < 20; k++) begin
      send_byte(fb[k], ok);
      if (ok) push(2'd0, fb[k]);
    end
    pkt_valid = 1'b0;
    chk("busy_after_pkt", 32'(busy), 32'd0);
    chk("error_full_pkt", 32'(error), 32'd0);
    drain_all();

    // Unread data on port 2: flushed by the timeout only when the option is built in
    send_vec(mk(3, 8'h06, 8'hA6, 8'hA0, 8'h00, 8'h00, 1'b0));
    repeat (40) @(negedge clk);
`ifdef ROUTER_SOFT_RESET_EN
    chk("timeout_valid2", 32'(vo[2]), 32'd0);
    exp_q2.delete();
`else
    chk("hold_valid2", 32'(vo[2]), 32'd1);
`endif
    drain_all();

    // Reset in the middle of a packet with error set and data_out nonzero
    send_vec(vecs[1]);
    read_one(1);
    read_one(1);
    chk("pre_rst_error", 32'(error), 32'd1);
    send_byte(8'h08, ok);
    if (ok) push(2'd0, 8'h08);
    send_byte(8'h55, ok);
    if (ok) push(2'd0, 8'h55);
    pkt_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(vo), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    chk("mid_rst_dout", {8'h00, d0, d1, d2}, 32'd0);
    chk("mid_rst_state", 32'(st), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    send_vec(vecs[4]);
    chk("post_rst_error", 32'(error), 32'd0);
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_modport.md
# router_modport

1x3 packet router: accepts byte-serial packets on one source port and steers each into one of three 16-deep output FIFOs by the header address. It checks packet parity. Each output has a read-side handshake made of `read_enb` (in), `valid_out` (out) and `data_out` (out), consumed by per-port read agents. It sits between the upstream packet source and three downstream byte readers.

## Interface
- `FIFO_DEPTH`, 16, entries per output FIFO (power of two).
- `clk` in 1: sole clock; all logic on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low; clears FSM, FIFOs, counters, outputs.
- `pkt_valid` in 1: source byte valid.
- `data_in` in 8: source byte.
- `busy` out 1: source must hold `data_in`/`pkt_valid` while high.
- `error` out 1: parity mismatch on last packet.
- `read_enb_0..2` in 1 each: pop request, per output port.
- `valid_out_0..2` out 1 each: FIFO n non-empty.
- `data_out_0..2` out 8 each: popped byte, registered.

## Operation
- **Packet format:**
  - Header byte: [7:2] = payload length L (1..63); [1:0] = destination (0..2).
  - Then L payload bytes, then 1 parity byte.
  - Parity is the XOR of the header and all payload bytes.
- A byte transfers on any rising edge with `pkt_valid`=1 and `busy`=0.
- **FSM states:**
  - IDLE: a transfer here is the header. Latch the address, load the counter with L, and seed the running parity with the header.
    - Destination 0..2: write the header to that FIFO and go to LOAD.
    - Destination 3: go to DROP.
  - LOAD: each transfer writes the payload byte to the FIFO and XORs it into the running parity. After byte L, go to PARITY.
  - PARITY: the transfer writes the parity byte to the FIFO and compares it to the running parity. `error` is set to the compare result. Return to IDLE.
  - FULL: entered whenever the selected FIFO is full. `busy`=1 and nothing is written. Return to the previous state when not full.
  - DROP: consume L+1 bytes with no writes and no `error` update, then go to IDLE.
- `busy` = 1 only in FULL, and in IDLE while the FIFO selected by the current `data_in`[1:0] is full (address 3 is never busy).
- `error` is held until the next PARITY evaluation.
- **Each output FIFO:**
  - Is a circular buffer with wrap-around pointers and a count.
  - `valid_out_n` = (count != 0).
  - On a rising edge with `read_enb_n`=1 and count != 0: `data_out_n` takes the head byte and the FIFO pops.
  - A read while empty leaves `data_out_n` unchanged.
- Simultaneous write and pop on the same FIFO: both occur and the count is unchanged. A write to a full FIFO never happens (FULL state).
- The three read ports are fully independent.
- Reset values:
  - `busy`, `error` = 0.
  - `valid_out_n` = 0.
  - `data_out_n` = 8'h00.
  - FSM = IDLE.
- Reset mid-packet discards all FIFO contents and the partial packet.

## Timing
- Write-to-visible latency: a byte written at edge k makes `valid_out_n`=1 after edge k.
- Read latency: `read_enb_n` sampled high at edge k puts the byte on `data_out_n` after edge k, i.e. 1 cycle.
- `valid_out_n` falls after the edge that pops the last byte.
- `busy` is combinational from state and FIFO-full and may change within a cycle. The source samples it before its next edge.
- `error` updates on the edge that accepts the parity byte.
- Back-to-back packets: a header may follow a parity byte on the next cycle.

## Configuration
- `ROUTER_SOFT_RESET_EN` defined:
  - Each port has a timeout counter that counts cycles with `valid_out_n`=1 and `read_enb_n`=0.
  - When the counter reaches 30, FIFO n is flushed (count, pointers to 0). `valid_out_n` falls next cycle.
  - If that FIFO is the current write target, the FSM returns to IDLE.
  - Any pop or an empty FIFO clears the counter.
- Undefined: no timeout; data waits indefinitely.

## Test plan
- Reset: assert `resetn`=0 mid-packet → all `valid_out_n`=0, `busy`=0, `error`=0, `data_out_n`=8'h00 immediately.
- Good packet: header 8'h0D (L=3, dest 1), payload 11/22/33, parity 8'h0D^11^22^33 → `valid_out_1`=1 with 5 bytes read back in order, `error`=0, ports 0/2 untouched.
- Bad parity: same packet with parity 8'hFF → `error`=1 after the parity edge, and the 5 bytes are still delivered.
- Full/backpressure: port 0 with 20-byte packet, no reads → `busy`=1 after the 16th byte. Read one byte → one more accepted. Data is intact across wrap-around.
- Invalid address: header 8'h07 (L=1, dest 3) plus 2 bytes → no FIFO written, `error` unchanged, next packet routes normally.
- Soft reset (macro on): write a packet to port 2, keep `read_enb_2`=0 for 30 cycles → `valid_out_2` drops to 0. With the macro off, it stays 1.
